regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- 32-entry x 64-bit ARM integer register file with two read ports and one write port.
- Sits directly upstream of the operand-select mux trees in the decode/execute path; read_data1/read_data2 feed the ALU-input and forwarding muxes.
- X31 is hardwired zero (XZR).
- Internal write-to-read bypass: a value written in the writeback stage is visible to decode in the same cycle, with no extra forwarding path.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS) = 5.
- ZERO_REG, 31, index hardwired to zero. Writes to it are discarded and reads of it return 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable, sampled at the rising edge.
- write_reg  input  5  destination register index.
- write_data  input  DATA_WIDTH  value to write.
- read_reg1  input  5  source index, port 1.
- read_reg2  input  5  source index, port 2.
- read_data1  output  DATA_WIDTH  combinational read data, port 1.
- read_data2  output  DATA_WIDTH  combinational read data, port 2.

Behaviour:
- Storage: NUM_REGS-1 real 64-bit registers (indices 0..30) built from D flip-flops. Index 31 has no storage.
- Reset:
  - If reset=1 at a rising edge, all stored registers become 0.
  - Reset has priority over a simultaneous write; that write is lost.
  - After the reset edge, every read returns 0.
  - Reset mid-stream discards all prior contents; no partial state survives.
- Write:
  - At a rising edge with reset=0, reg_write=1 and write_reg != 31: register[write_reg] <= write_data.
  - All other registers hold their value.
  - reg_write=0 means no state change.
  - write_reg=31 means no state change, whatever reg_write is.
- Read (combinational, zero-cycle latency), port n:
  - read_reg=31 -> output 0, always (highest priority).
  - Else, if reset=0, reg_write=1 and write_reg == read_reg -> output write_data (bypass).
  - Else -> output stored register[read_reg].
- Bypass is suppressed while reset=1; outputs then show stored contents, and show 0 after the edge.
- Both ports are fully independent:
  - Both may address the same register.
  - Both may bypass in the same cycle.
- No X propagation: every output bit is driven from the cycle after the first reset edge onward.
- Read-decode structure: 5-bit index into a 32:1 mux per bit, built as a tree of the team's 2:1 and 4:1 mux cells.
- Write decode: 5:32 decoder ANDed with reg_write; the decoder output at 31 is unused.
- Timing: one write per cycle maximum. A write is architecturally visible to reads in the same cycle via the bypass, and from the stored copy from the next cycle on.

Test Plan:
- Reset clears state:
  - Stimulus: write 0xDEAD_BEEF_0000_0001 to X5; assert reset for 1 cycle; read X5 on both ports.
  - Required: 0 on both ports.
- Reset beats a simultaneous write:
  - Stimulus: reset=1, reg_write=1, write_reg=7, write_data=0x1234 at the same edge.
  - Required: X7 reads 0 afterwards.
- Full sweep:
  - Stimulus: write value (i * 0x0101_0101_0101_0101) to Xi for i=0..30 on consecutive cycles; then read all 32 indices on both ports.
  - Required: each Xi returns its value and X31 returns 0.
- XZR protection:
  - Stimulus: reg_write=1, write_reg=31, write_data=0xFFFF_FFFF_FFFF_FFFF; read_reg1=31.
  - Required: read_data1=0 in that cycle and in the next; X0..X30 unchanged.
- Same-cycle bypass:
  - Stimulus: X3 holds 0x11; in one cycle drive reg_write=1, write_reg=3, write_data=0x22, read_reg1=3, read_reg2=3.
  - Required: both ports show 0x22 before the edge; X3 stores 0x22 after the edge.
- Write-enable low:
  - Stimulus: reg_write=0, write_reg=4, write_data=0x99, read_reg2=4, with X4 holding 0x44.
  - Required: read_data2=0x44 in that cycle and in the next.

Source files
------------

// File: rtl/regfile_bypass.sv
// 31 x 64-bit integer register file with a hardwired-zero index, two combinational
// read ports and one write port whose data bypasses to same-cycle reads.
module regfile_bypass #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // The read tree below is three levels (4:1, 4:1, 2:1) and covers exactly 32 leaves.
  localparam int NUM_PORTS = 2;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                 w_wr_dec;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_leaf;
  logic [4:0]                          w_sel     [NUM_PORTS];
  logic [DATA_WIDTH-1:0]               w_lvl1    [NUM_PORTS][8];
  logic [DATA_WIDTH-1:0]               w_lvl2    [NUM_PORTS][2];
  logic [DATA_WIDTH-1:0]               w_tree    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]               w_rd      [NUM_PORTS];

  function automatic logic [DATA_WIDTH-1:0] mux2(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  s
  );
    return s ? b : a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mux4(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            s
  );
    logic [DATA_WIDTH-1:0] y;
    case (s)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
    return y;
  endfunction

  // One-hot write strobe; the ZERO_REG line is never used.
  assign w_wr_dec = {{(NUM_REGS-1){1'b0}}, reg_write} << write_reg;

  // The ZERO_REG entry is cleared on reset and never written, so it folds to a constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i != ZERO_REG && w_wr_dec[i]) begin
          r_regs[i] <= write_data;
        end
      end
    end
  end

  always_comb begin
    w_leaf = r_regs;
    w_leaf[ZERO_REG] = '0;
  end

  assign w_sel[0] = read_reg1;
  assign w_sel[1] = read_reg2;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int g = 0; g < 8; g++) begin
        w_lvl1[p][g] = mux4(w_leaf[4*g], w_leaf[4*g+1], w_leaf[4*g+2], w_leaf[4*g+3],
                            w_sel[p][1:0]);
      end
      for (int g = 0; g < 2; g++) begin
        w_lvl2[p][g] = mux4(w_lvl1[p][4*g], w_lvl1[p][4*g+1], w_lvl1[p][4*g+2],
                            w_lvl1[p][4*g+3], w_sel[p][3:2]);
      end
      w_tree[p] = mux2(w_lvl2[p][0], w_lvl2[p][1], w_sel[p][4]);

      // Zero index wins, then the writeback bypass (held off during reset), then storage.
      if (w_sel[p] == 5'(ZERO_REG)) begin
        w_rd[p] = '0;
      end else if (!reset && reg_write && (write_reg == w_sel[p])) begin
        w_rd[p] = write_data;
      end else begin
        w_rd[p] = w_tree[p];
      end
    end
  end

  assign read_data1 = w_rd[0];
  assign read_data2 = w_rd[1];

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed vector table, register sweep, and random traffic
// checked against an array-based model of the architectural register state.
module tb_regfile_bypass;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int n_cmp;
  int n_err;

  // Architectural state model: plain array of the 31 real registers.
  logic [63:0] model [31];

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t tbl [16];

  regfile_bypass dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic rst, input logic we,
                                             input logic [4:0] wr, input logic [63:0] wd,
                                             input logic [4:0] rr);
    if (rr == 5'd31) return 64'd0;
    if (!rst && we && wr == rr) return wd;
    return model[rr];
  endfunction

  // One clock cycle: drive after the falling edge, compare before the rising edge,
  // then advance the model to what the rising edge commits.
  task automatic apply(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2, input string name);
    @(negedge clk);
    reset      = rst;
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
    #2;
    check({name, ".rd1"}, read_data1, e1);
    check({name, ".rd2"}, read_data2, e2);
    if (rst) begin
      for (int i = 0; i < 31; i++) model[i] = 64'd0;
    end else if (we && wr != 5'd31) begin
      model[wr] = wd;
    end
  endtask

  task automatic apply_model(input logic rst, input logic we, input logic [4:0] wr,
                             input logic [63:0] wd, input logic [4:0] r1,
                             input logic [4:0] r2, input string name);
    logic [63:0] e1;
    logic [63:0] e2;
    e1 = model_read(rst, we, wr, wd, r1);
    e2 = model_read(rst, we, wr, wd, r2);
    apply(rst, we, wr, wd, r1, r2, e1, e2, name);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 64'd0;
    read_reg1  = 5'd31;
    read_reg2  = 5'd31;

    //              rst   we    wr     wd                       r1     r2     e1                       e2
    tbl[0]  = '{1'b1, 1'b1, 5'd7,  64'h1234,                5'd31, 5'd31, 64'd0,                   64'd0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd7,  5'd7,  64'd0,                   64'd0};
    tbl[2]  = '{1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 5'd5,  5'd0,  64'hDEAD_BEEF_0000_0001, 64'd0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd5,  5'd5,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    tbl[4]  = '{1'b1, 1'b0, 5'd0,  64'd0,                   5'd5,  5'd5,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd5,  5'd5,  64'd0,                   64'd0};
    tbl[6]  = '{1'b0, 1'b1, 5'd3,  64'h11,                  5'd3,  5'd4,  64'h11,                  64'd0};
    tbl[7]  = '{1'b0, 1'b1, 5'd4,  64'h44,                  5'd3,  5'd4,  64'h11,                  64'h44};
    tbl[8]  = '{1'b0, 1'b1, 5'd3,  64'h22,                  5'd3,  5'd3,  64'h22,                  64'h22};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd3,  5'd3,  64'h22,                  64'h22};
    tbl[10] = '{1'b0, 1'b0, 5'd4,  64'h99,                  5'd3,  5'd4,  64'h22,                  64'h44};
    tbl[11] = '{1'b0, 1'b0, 5'd4,  64'h99,                  5'd4,  5'd4,  64'h44,                  64'h44};
    tbl[12] = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd3,  64'd0,                   64'h22};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd31, 5'd4,  64'd0,                   64'h44};
    tbl[14] = '{1'b1, 1'b1, 5'd3,  64'h55,                  5'd3,  5'd3,  64'h22,                  64'h22};
    tbl[15] = '{1'b0, 1'b0, 5'd0,  64'd0,                   5'd3,  5'd4,  64'd0,                   64'd0};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].rst, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].r1, tbl[i].r2,
            tbl[i].e1, tbl[i].e2, $sformatf("vec%0d", i));
    end

    // Full sweep: fill X0..X30, read back every index on both ports.
    for (int i = 0; i < 31; i++) begin
      logic [63:0] v;
      v = 64'(i) * 64'h0101_0101_0101_0101;
      apply(1'b0, 1'b1, 5'(i), v, 5'd31, 5'd31, 64'd0, 64'd0, $sformatf("fill%0d", i));
    end
    for (int i = 0; i < 32; i++) begin
      logic [63:0] v1;
      logic [63:0] v2;
      v1 = (i == 31) ? 64'd0 : 64'(i) * 64'h0101_0101_0101_0101;
      v2 = (i == 0) ? 64'd0 : 64'(31 - i) * 64'h0101_0101_0101_0101;
      apply(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), v1, v2, $sformatf("sweep%0d", i));
    end

    // XZR write attempt, then confirm nothing moved.
    apply(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'd0, 64'd0, "xzr_w");
    apply(1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'd0, 64'd0, "xzr_n");
    for (int i = 0; i < 31; i++) begin
      logic [63:0] v;
      v = 64'(i) * 64'h0101_0101_0101_0101;
      apply(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'd31, v, 64'd0, $sformatf("xzr_keep%0d", i));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic        rst;
      logic        we;
      logic [4:0]  wr;
      logic [63:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      rst = ($urandom_range(0, 49) == 0);
      we  = $urandom_range(0, 2) != 0;
      wr  = 5'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      apply_model(rst, we, wr, wd, r1, r2, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
